// File: rtl/hack_mem_ctrl.sv
// hack_mem_ctrl: Hack CPU M-port controller (data RAM, screen-write FIFO, keyboard latch).
// Optional: define MEM_CTRL_KBD_CLEAR_ON_READ_EN to make keyboard reads clear the latch.
module hack_mem_ctrl #(
  parameter int DATA_DEPTH     = 256,
  parameter int SCR_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_din,
  output logic        ram_we,
  input  logic [15:0] ram_dout,
  output logic        scr_valid,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  input  logic        scr_ready,
  input  logic [15:0] kbd_code,
  input  logic        kbd_strobe,
  output logic        err_sticky
);
  localparam int PTR_W = (SCR_FIFO_DEPTH > 1) ? $clog2(SCR_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(SCR_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RAM_ISSUE, RAM_WAIT, DONE} state_t;

  state_t           state_reg;
  logic             pend_read_reg;
  logic [15:0]      kbd_latch_reg;
  logic [28:0]      fifo_mem [SCR_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic sel_ram, ram_in_range, sel_scr, sel_kbd;
  logic fifo_full, scr_push, scr_pop;

  always_comb begin
    sel_ram      = ~cpu_addr[14];
    ram_in_range = sel_ram && ({17'd0, cpu_addr} < 32'(DATA_DEPTH));
    sel_scr      = (cpu_addr[14:13] == 2'b10);
    sel_kbd      = (cpu_addr == 15'h6000);
    fifo_full    = (count_reg == FIFO_FULL);
    scr_push     = (state_reg == IDLE) && cpu_req && sel_scr && cpu_we && !fifo_full;
    scr_pop      = (count_reg != '0) && scr_ready;
  end

  // Control FSM; every non-RAM target completes straight from IDLE into DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      pend_read_reg <= 1'b0;
      cpu_ready     <= 1'b0;
      cpu_rdata     <= '0;
      ram_addr      <= '0;
      ram_din       <= '0;
      ram_we        <= 1'b0;
      err_sticky    <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cpu_req) begin
            if (ram_in_range) begin
              ram_addr      <= {1'b0, cpu_addr};
              ram_din       <= cpu_wdata;
              ram_we        <= cpu_we;
              pend_read_reg <= ~cpu_we;
              state_reg     <= RAM_ISSUE;
            end else if (sel_scr && cpu_we) begin
              if (!fifo_full) begin
                cpu_rdata <= '0;
                cpu_ready <= 1'b1;
                state_reg <= DONE;
              end
            end else begin
              cpu_rdata <= (sel_kbd && !cpu_we) ? kbd_latch_reg : 16'h0000;
              cpu_ready <= 1'b1;
              state_reg <= DONE;
              if (sel_ram || (sel_kbd && cpu_we) || !(sel_scr || sel_kbd))
                err_sticky <= 1'b1;
            end
          end
        end
        RAM_ISSUE: begin
          ram_we <= 1'b0;
          if (pend_read_reg) begin
            state_reg <= RAM_WAIT;
          end else begin
            cpu_rdata <= '0;
            cpu_ready <= 1'b1;
            state_reg <= DONE;
          end
        end
        RAM_WAIT: begin
          cpu_rdata <= ram_dout;
          cpu_ready <= 1'b1;
          state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef MEM_CTRL_KBD_CLEAR_ON_READ_EN
  logic kbd_read_accept;
  assign kbd_read_accept = (state_reg == IDLE) && cpu_req && sel_kbd && !cpu_we;
`endif

  // A strobe always wins over the optional clear-on-read.
  always_ff @(posedge clk) begin
    if (reset)
      kbd_latch_reg <= '0;
    else if (kbd_strobe)
      kbd_latch_reg <= kbd_code;
`ifdef MEM_CTRL_KBD_CLEAR_ON_READ_EN
    else if (kbd_read_accept)
      kbd_latch_reg <= '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (scr_push)
      fifo_mem[wr_ptr_reg] <= {cpu_addr[12:0], cpu_wdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (scr_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (scr_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (scr_push && !scr_pop)
        count_reg <= count_reg + 1'b1;
      else if (scr_pop && !scr_push)
        count_reg <= count_reg - 1'b1;
    end
  end

  // Head is masked so the outputs read zero whenever the FIFO is empty.
  assign scr_valid            = (count_reg != '0);
  assign {scr_addr, scr_data} = scr_valid ? fifo_mem[rd_ptr_reg] : 29'd0;

endmodule

// File: tb/tb_hack_mem_ctrl.sv
// tb_hack_mem_ctrl: scoreboard bench for hack_mem_ctrl with a behavioural Hack memory-map model.
module tb_hack_mem_ctrl;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic [15:0] ram_addr, ram_din, ram_dout;
  logic        ram_we;
  logic        scr_valid, scr_ready;
  logic [12:0] scr_addr;
  logic [15:0] scr_data, kbd_code;
  logic        kbd_strobe, err_sticky;
  logic        ram_clr;

  always #5 clk = ~clk;

  hack_mem_ctrl #(.DATA_DEPTH(DEPTH), .SCR_FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .scr_valid(scr_valid), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ready(scr_ready),
    .kbd_code(kbd_code), .kbd_strobe(kbd_strobe), .err_sticky(err_sticky)
  );

  // Data RAM attached to the controller: registered 1-cycle read.
  logic [15:0] ram_arr [DEPTH];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) ram_arr[i] <= '0;
    end else if (ram_we) begin
      ram_arr[ram_addr[7:0]] <= ram_din;
    end
    ram_dout <= ram_arr[ram_addr[7:0]];
  end

  typedef struct { logic [15:0] rdata; int lat; logic err; } exp_t;
  typedef struct { logic [12:0] a; logic [15:0] d; } scr_t;
  exp_t  exp_q[$];
  string name_q[$];
  scr_t  scr_q[$];

  logic [15:0] ref_mem [DEPTH];
  logic        m_err;
  logic [15:0] m_kbd;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, issue_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: Hack memory map from the address rules, with per-target latency.
  task automatic model(input logic we, input logic [14:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output int lat);
    rd  = 16'h0000;
    lat = 1;
    if (a < 15'h4000) begin
      if (int'(a) < DEPTH) begin
        lat = we ? 2 : 3;
        if (we) ref_mem[a[7:0]] = d;
        else    rd = ref_mem[a[7:0]];
      end else begin
        m_err = 1'b1;
      end
    end else if (a < 15'h6000) begin
      if (we) begin
        scr_t s;
        s.a = 13'(a - 15'h4000);
        s.d = d;
        scr_q.push_back(s);
      end
    end else if (a == 15'h6000) begin
      if (we) m_err = 1'b1;
      else begin
        rd = m_kbd;
`ifdef MEM_CTRL_KBD_CLEAR_ON_READ_EN
        m_kbd = 16'h0000;
`endif
      end
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_err = 1'b0;
    m_kbd = 16'h0000;
    scr_q.delete();
  endtask

  task automatic start(input logic we, input logic [14:0] a, input logic [15:0] d,
                       input string nm, input bit track, input bit stall);
    exp_t        e;
    logic [15:0] rd;
    int          lat;
    model(we, a, d, rd, lat);
    if (track) begin
      e.rdata = rd;
      e.lat   = stall ? -1 : lat;
      e.err   = m_err;
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    issue_cyc = cyc;
  endtask

  task automatic finish(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ready && n < 40);
    if (!cpu_ready) chk({nm, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic kbd_pulse(input logic [15:0] code);
    kbd_code = code; kbd_strobe = 1'b1;
    @(posedge clk); #1;
    kbd_strobe = 1'b0;
    m_kbd = code;
  endtask

  // Monitor: pops the scoreboards whenever the DUT completes a request or the display consumes.
  always @(negedge clk) begin
    exp_t  e;
    scr_t  s;
    string nm;
    if (!reset) begin
      if (cpu_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          chk({nm, "_rdata"}, 32'(cpu_rdata), 32'(e.rdata));
          if (e.lat >= 0) chk({nm, "_latency"}, 32'(cyc - issue_cyc), 32'(e.lat));
          chk({nm, "_err"}, 32'(err_sticky), 32'(e.err));
        end
        $display("txn %s addr=0x%04h we=%0d rdata=0x%04h err=%0d", nm, cpu_addr, cpu_we, cpu_rdata, err_sticky);
      end
      if (scr_valid && scr_ready) begin
        if (scr_q.size() == 0) begin
          chk("unexpected_scr_pop", 32'd1, 32'd0);
        end else begin
          s = scr_q.pop_front();
          chk("scr_addr", 32'(scr_addr), 32'(s.a));
          chk("scr_data", 32'(scr_data), 32'(s.d));
          $display("scr pop off=0x%04h data=0x%04h", scr_addr, scr_data);
        end
      end
      if (ram_we) chk("ram_we_in_range", 32'(int'(ram_addr) < DEPTH), 32'd1);
    end
  end

  initial begin
    reset = 1'b1; ram_clr = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    scr_ready = 1'b0; kbd_code = '0; kbd_strobe = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_scr_valid", 32'(scr_valid), 32'd0);
    chk("rst_scr_addr", 32'(scr_addr), 32'd0);
    chk("rst_scr_data", 32'(scr_data), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; ram_clr = 1'b0;

    // RAM write then read-back
    start(1'b1, 15'h0005, 16'h1234, "ram_wr", 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("ram_wr_we_pulse", 32'(ram_we), 32'd1);
    chk("ram_wr_addr", 32'(ram_addr), 32'h5);
    chk("ram_wr_din", 32'(ram_din), 32'h1234);
    finish("ram_wr");
    start(1'b0, 15'h0005, 16'h0000, "ram_rd", 1, 0);
    finish("ram_rd");

    // Beyond physical depth: unmapped
    start(1'b0, 15'h0100, 16'h0000, "ram_oor_rd", 1, 0);
    finish("ram_oor_rd");

    // Screen FIFO fill, stall on full, drain in order
    scr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start(1'b1, 15'(15'h4000 + i), 16'(16'hA000 + i), "scr_wr", 1, 0);
      finish("scr_wr");
    end
    start(1'b1, 15'h4004, 16'hA004, "scr_wr_stall", 1, 1);
    repeat (4) begin
      @(negedge clk);
      chk("scr_stall_no_ready", 32'(cpu_ready), 32'd0);
    end
    chk("scr_full_head_addr", 32'(scr_addr), 32'h0);
    chk("scr_full_head_data", 32'(scr_data), 32'hA000);
    @(posedge clk); #1;
    scr_ready = 1'b1;
    finish("scr_wr_stall");
    repeat (8) @(negedge clk);
    chk("scr_drained", 32'(scr_q.size()), 32'd0);

    // Keyboard latch
    kbd_pulse(16'h0041);
    start(1'b0, 15'h6000, 16'h0000, "kbd_rd1", 1, 0);
    finish("kbd_rd1");
    start(1'b0, 15'h6000, 16'h0000, "kbd_rd2", 1, 0);
    finish("kbd_rd2");

    // Reset during RAM_WAIT with a screen write still queued
    scr_ready = 1'b0;
    start(1'b1, 15'h4010, 16'hBEEF, "scr_queued", 1, 0);
    finish("scr_queued");
    start(1'b0, 15'h0005, 16'h0000, "rd_abort", 0, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    chk("abort_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("abort_ram_we", 32'(ram_we), 32'd0);
    chk("abort_ram_addr", 32'(ram_addr), 32'd0);
    chk("abort_err", 32'(err_sticky), 32'd0);
    chk("abort_scr_valid", 32'(scr_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = 1'b0; scr_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Keyboard write and unmapped read
    start(1'b1, 15'h6000, 16'h5555, "kbd_wr", 1, 0);
    finish("kbd_wr");
    start(1'b0, 15'h7000, 16'h0000, "unmapped_rd", 1, 0);
    finish("unmapped_rd");

    // Randomised traffic across the whole map
    for (int n = 0; n < 150; n++) begin
      logic [14:0] a;
      logic        we;
      int          cls;
      if ($urandom_range(0, 7) == 0) kbd_pulse(16'($urandom));
      cls = int'($urandom_range(0, 9));
      we  = 1'($urandom);
      case (cls)
        0, 1, 2, 3, 4: a = 15'($urandom_range(0, DEPTH - 1));
        5:             a = 15'($urandom_range(DEPTH, 32'h3FFF));
        6, 7:          a = 15'($urandom_range(32'h4000, 32'h5FFF));
        8:             a = 15'h6000;
        default:       a = 15'($urandom_range(32'h6001, 32'h7FFF));
      endcase
      start(we, a, 16'($urandom), "rnd", 1, 0);
      finish("rnd");
    end

    repeat (10) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("scr_q_empty", 32'(scr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
